lsu_mem_port: RTL and testbench

Parametrised, multi-cycle load/store port between the execute stage and the data-memory bus. It replaces the single-cycle combinational memory access with a valid/ready request/response handshake toward the core and a req/gnt/rvalid handshake toward memory. Store lane alignment, byte-strobe generation and load sign/zero extension are done in the block. Misaligned accesses, bus errors and bus timeouts are reported as RISC-V exception causes for the trap logic.

---
 rtl/lsu_mem_port.sv | 174 +++++++++++++++++
 tb/tb_lsu_mem_port.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_mem_port.sv
`default_nettype none
// lsu_mem_port: multi-cycle load/store port bridging a valid/ready core interface to a req/gnt/rvalid memory bus.
// Does store lane alignment, byte strobes, load extension, and misalign / bus-error / timeout trap reporting.
module lsu_mem_port #(
    parameter int XLEN    = 32,
    parameter int ADDR_W  = 32,
    parameter int TIMEOUT = 255
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [XLEN-1:0]   i_req_wdata,
    output logic              o_resp_valid,
    input  logic              i_resp_ready,
    output logic [XLEN-1:0]   o_resp_rdata,
    output logic              o_resp_err,
    output logic [3:0]        o_resp_cause,
    output logic              o_bus_req,
    input  logic              i_bus_gnt,
    output logic              o_bus_we,
    output logic [ADDR_W-1:0] o_bus_addr,
    output logic [XLEN-1:0]   o_bus_wdata,
    output logic [XLEN/8-1:0] o_bus_wstrb,
    input  logic              i_bus_rvalid,
    input  logic [XLEN-1:0]   i_bus_rdata,
    input  logic              i_bus_err
);
    localparam int NB = XLEN / 8;
    localparam int LW = $clog2(NB);
    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_WAIT = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t            r_state;
    state_t            w_next;
    logic              r_we;
    logic              r_unsigned;
    logic [1:0]        r_size;
    logic [LW-1:0]     r_lane;
    logic [ADDR_W-1:0] r_bus_addr;
    logic [XLEN-1:0]   r_bus_wdata;
    logic [NB-1:0]     r_bus_wstrb;
    logic [CW-1:0]     r_cnt;
    logic [XLEN-1:0]   r_resp_rdata;
    logic              r_resp_err;
    logic [3:0]        r_resp_cause;

    logic [LW-1:0]     w_lane;
    logic              w_misal;
    logic [7:0]        w_mask8;
    logic              w_tmo;
    logic              w_done;
    logic [XLEN-1:0]   w_shift;
    logic [63:0]       w_sh64;
    logic [63:0]       w_ld64;

    assign w_lane = i_req_addr[LW-1:0];

    // Size 3 only exists on a 64-bit bus; on XLEN=32 it is reported as misaligned.
    always_comb begin
        w_misal = 1'b0;
        w_mask8 = 8'h01;
        case (i_req_size)
            2'd0: w_mask8 = 8'h01;
            2'd1: begin w_misal = i_req_addr[0];                        w_mask8 = 8'h03; end
            2'd2: begin w_misal = |i_req_addr[1:0];                     w_mask8 = 8'h0F; end
            default: begin w_misal = (XLEN == 32) || (|i_req_addr[2:0]); w_mask8 = 8'hFF; end
        endcase
    end

    assign w_tmo  = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
    assign w_done = (r_state == S_WAIT) && i_bus_rvalid;

    assign w_shift = i_bus_rdata >> {r_lane, 3'b000};
    assign w_sh64  = 64'(w_shift);

    always_comb begin
        w_ld64 = w_sh64;
        case (r_size)
            2'd0:    w_ld64 = {{56{~r_unsigned & w_sh64[7]}},  w_sh64[7:0]};
            2'd1:    w_ld64 = {{48{~r_unsigned & w_sh64[15]}}, w_sh64[15:0]};
            2'd2:    w_ld64 = {{32{~r_unsigned & w_sh64[31]}}, w_sh64[31:0]};
            default: w_ld64 = w_sh64;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_next;
    end

    // Timeout takes priority over a grant in REQ; in WAIT a same-cycle rvalid wins.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: if (i_req_valid) w_next = w_misal ? S_RESP : S_REQ;
            S_REQ:  begin
                if (w_tmo)          w_next = S_RESP;
                else if (i_bus_gnt) w_next = S_WAIT;
            end
            S_WAIT: if (i_bus_rvalid || w_tmo) w_next = S_RESP;
            S_RESP: if (i_resp_ready) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_we         <= 1'b0;
            r_unsigned   <= 1'b0;
            r_size       <= 2'd0;
            r_lane       <= '0;
            r_bus_addr   <= '0;
            r_bus_wdata  <= '0;
            r_bus_wstrb  <= '0;
            r_cnt        <= '0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_resp_cause <= 4'd0;
        end else begin
            case (r_state)
                S_IDLE: if (i_req_valid) begin
                    r_we         <= i_req_we;
                    r_unsigned   <= i_req_unsigned;
                    r_size       <= i_req_size;
                    r_lane       <= w_lane;
                    r_bus_addr   <= i_req_addr & ~ADDR_W'(NB - 1);
                    r_bus_wdata  <= i_req_wdata << {w_lane, 3'b000};
                    r_bus_wstrb  <= i_req_we ? (w_mask8[NB-1:0] << w_lane) : '0;
                    r_cnt        <= '0;
                    r_resp_rdata <= '0;
                    r_resp_err   <= w_misal;
                    r_resp_cause <= w_misal ? (i_req_we ? 4'd6 : 4'd4) : 4'd0;
                end
                S_REQ, S_WAIT: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_done) begin
                        r_resp_err   <= i_bus_err;
                        r_resp_cause <= i_bus_err ? (r_we ? 4'd7 : 4'd5) : 4'd0;
                        r_resp_rdata <= (i_bus_err || r_we) ? '0 : w_ld64[XLEN-1:0];
                    end else if (w_tmo) begin
                        r_resp_err   <= 1'b1;
                        r_resp_cause <= r_we ? 4'd7 : 4'd5;
                        r_resp_rdata <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_req_ready  = (r_state == S_IDLE);
    assign o_resp_valid = (r_state == S_RESP);
    assign o_resp_rdata = r_resp_rdata;
    assign o_resp_err   = r_resp_err;
    assign o_resp_cause = r_resp_cause;
    assign o_bus_req    = (r_state == S_REQ);
    assign o_bus_we     = r_we;
    assign o_bus_addr   = r_bus_addr;
    assign o_bus_wdata  = r_bus_wdata;
    assign o_bus_wstrb  = r_bus_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_lsu_mem_port.sv
`default_nettype none
// tb_lsu_mem_port: self-checking bench for lsu_mem_port, a 32-bit instance (default timeout)
// and a 64-bit instance with TIMEOUT=4, checked against an arithmetic reference model.
module tb_lsu_mem_port;
    localparam int TO_B = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        a_req_valid = 0, a_req_we = 0, a_req_unsigned = 0, a_resp_ready = 0;
    logic [1:0]  a_req_size = 0;
    logic [31:0] a_req_addr = 0, a_req_wdata = 0, a_bus_rdata = 0;
    logic        a_bus_gnt = 0, a_bus_rvalid = 0, a_bus_err = 0;
    logic        a_req_ready, a_resp_valid, a_resp_err, a_bus_req, a_bus_we;
    logic [31:0] a_resp_rdata, a_bus_addr, a_bus_wdata;
    logic [3:0]  a_resp_cause, a_bus_wstrb;

    logic        b_req_valid = 0, b_req_we = 0, b_req_unsigned = 0, b_resp_ready = 0;
    logic [1:0]  b_req_size = 0;
    logic [31:0] b_req_addr = 0;
    logic [63:0] b_req_wdata = 0, b_bus_rdata = 0;
    logic        b_bus_gnt = 0, b_bus_rvalid = 0, b_bus_err = 0;
    logic        b_req_ready, b_resp_valid, b_resp_err, b_bus_req, b_bus_we;
    logic [63:0] b_resp_rdata, b_bus_wdata;
    logic [31:0] b_bus_addr;
    logic [3:0]  b_resp_cause;
    logic [7:0]  b_bus_wstrb;

    lsu_mem_port #(.XLEN(32), .ADDR_W(32)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(a_req_valid), .o_req_ready(a_req_ready), .i_req_we(a_req_we),
        .i_req_size(a_req_size), .i_req_unsigned(a_req_unsigned), .i_req_addr(a_req_addr),
        .i_req_wdata(a_req_wdata), .o_resp_valid(a_resp_valid), .i_resp_ready(a_resp_ready),
        .o_resp_rdata(a_resp_rdata), .o_resp_err(a_resp_err), .o_resp_cause(a_resp_cause),
        .o_bus_req(a_bus_req), .i_bus_gnt(a_bus_gnt), .o_bus_we(a_bus_we), .o_bus_addr(a_bus_addr),
        .o_bus_wdata(a_bus_wdata), .o_bus_wstrb(a_bus_wstrb), .i_bus_rvalid(a_bus_rvalid),
        .i_bus_rdata(a_bus_rdata), .i_bus_err(a_bus_err)
    );

    lsu_mem_port #(.XLEN(64), .ADDR_W(32), .TIMEOUT(TO_B)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(b_req_valid), .o_req_ready(b_req_ready), .i_req_we(b_req_we),
        .i_req_size(b_req_size), .i_req_unsigned(b_req_unsigned), .i_req_addr(b_req_addr),
        .i_req_wdata(b_req_wdata), .o_resp_valid(b_resp_valid), .i_resp_ready(b_resp_ready),
        .o_resp_rdata(b_resp_rdata), .o_resp_err(b_resp_err), .o_resp_cause(b_resp_cause),
        .o_bus_req(b_bus_req), .i_bus_gnt(b_bus_gnt), .o_bus_we(b_bus_we), .o_bus_addr(b_bus_addr),
        .o_bus_wdata(b_bus_wdata), .o_bus_wstrb(b_bus_wstrb), .i_bus_rvalid(b_bus_rvalid),
        .i_bus_rdata(b_bus_rdata), .i_bus_err(b_bus_err)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference: byte-lane arithmetic on an nb-byte bus word.
    function automatic void model(input int nb, input logic we, input logic [1:0] sz, input logic un,
                                  input logic [63:0] ad, input logic [63:0] wd, input logic [63:0] rd,
                                  output logic mis, output logic [63:0] baddr, output logic [63:0] bwd,
                                  output logic [63:0] bstrb, output logic [63:0] ld);
        int n;
        int lane;
        logic [63:0] mask;
        logic [63:0] wmask;
        n     = 1 << sz;
        lane  = int'(ad % 64'(nb));
        wmask = (nb == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : 64'hFFFF_FFFF;
        mis   = (n > nb) || ((ad % 64'(n)) != 0);
        baddr = ad - 64'(lane);
        bstrb = we ? (((64'd1 << n) - 64'd1) << lane) : 64'd0;
        bwd   = (wd << (8 * lane)) & wmask;
        mask  = (n == 8) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (8 * n)) - 64'd1);
        ld    = (rd >> (8 * lane)) & mask;
        if (!un && ld[8*n-1]) ld = ld | ~mask;
        ld    = ld & wmask;
    endfunction

    task automatic chk_rst_a();
        chk("rst_req_ready", a_req_ready, 1);
        chk("rst_resp_valid", a_resp_valid, 0);
        chk("rst_resp_err", a_resp_err, 0);
        chk("rst_resp_cause", a_resp_cause, 0);
        chk("rst_resp_rdata", a_resp_rdata, 0);
        chk("rst_bus_req", a_bus_req, 0);
        chk("rst_bus_we", a_bus_we, 0);
        chk("rst_bus_wstrb", a_bus_wstrb, 0);
        chk("rst_bus_addr", a_bus_addr, 0);
        chk("rst_bus_wdata", a_bus_wdata, 0);
    endtask

    // Called at a negedge with the 32-bit port idle; returns at a negedge with it idle again.
    task automatic acc_a(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] ad,
                         input logic [31:0] wd, input logic [31:0] rd, input logic be,
                         input int gd, input int rvd, input int rrd);
        logic mis;
        logic [63:0] eaddr, ewd, estrb, eld, erd;
        logic eerr;
        logic [3:0] ecause;
        model(4, we, sz, un, 64'(ad), 64'(wd), 64'(rd), mis, eaddr, ewd, estrb, eld);
        eerr   = mis || be;
        ecause = mis ? (we ? 4'd6 : 4'd4) : (be ? (we ? 4'd7 : 4'd5) : 4'd0);
        erd    = (eerr || we) ? 64'd0 : eld;
        chk("a_req_ready_idle", a_req_ready, 1);
        a_req_valid = 1; a_req_we = we; a_req_size = sz; a_req_unsigned = un;
        a_req_addr = ad; a_req_wdata = wd;
        @(negedge clk);
        a_req_valid = 0; a_req_wdata = $urandom; a_req_addr = $urandom;
        if (mis) begin
            chk("a_misal_no_bus_req", a_bus_req, 0);
        end else begin
            for (int k = 0; k <= gd; k++) begin
                chk("a_bus_req", a_bus_req, 1);
                chk("a_bus_addr", a_bus_addr, eaddr);
                chk("a_bus_wstrb", a_bus_wstrb, estrb);
                chk("a_bus_we", a_bus_we, we);
                if (we) chk("a_bus_wdata", a_bus_wdata, ewd);
                if (k == gd) a_bus_gnt = 1;
                @(negedge clk);
                a_bus_gnt = 0;
            end
            chk("a_bus_req_wait", a_bus_req, 0);
            for (int j = 0; j <= rvd; j++) begin
                chk("a_resp_valid_early", a_resp_valid, 0);
                if (j == rvd) begin a_bus_rvalid = 1; a_bus_rdata = rd; a_bus_err = be; end
                @(negedge clk);
                a_bus_rvalid = 0; a_bus_err = 0; a_bus_rdata = $urandom;
            end
        end
        for (int m = 0; m <= rrd; m++) begin
            chk("a_resp_valid", a_resp_valid, 1);
            chk("a_req_ready_busy", a_req_ready, 0);
            chk("a_resp_err", a_resp_err, eerr);
            chk("a_resp_cause", a_resp_cause, ecause);
            chk("a_resp_rdata", a_resp_rdata, erd);
            if (m == rrd) a_resp_ready = 1;
            @(negedge clk);
            a_resp_ready = 0;
        end
        chk("a_resp_valid_done", a_resp_valid, 0);
    endtask

    // 64-bit port with immediate grant; rvd<0 means the bus never completes.
    task automatic acc_b(input logic we, input logic [1:0] sz, input logic un, input logic [31:0] ad,
                         input logic [63:0] wd, input logic [63:0] rd, input int rvd);
        logic mis;
        logic [63:0] eaddr, ewd, estrb, eld, erd;
        logic tmo;
        int exp_cyc;
        int cyc;
        model(8, we, sz, un, 64'(ad), wd, rd, mis, eaddr, ewd, estrb, eld);
        tmo     = (rvd < 0) || (2 + rvd > TO_B);
        exp_cyc = tmo ? TO_B + 1 : 3 + rvd;
        erd     = (tmo || we) ? 64'd0 : eld;
        chk("b_req_ready_idle", b_req_ready, 1);
        b_req_valid = 1; b_req_we = we; b_req_size = sz; b_req_unsigned = un;
        b_req_addr = ad; b_req_wdata = wd;
        @(negedge clk);
        b_req_valid = 0;
        chk("b_bus_req", b_bus_req, 1);
        chk("b_bus_addr", b_bus_addr, eaddr);
        chk("b_bus_wstrb", b_bus_wstrb, estrb);
        if (we) chk("b_bus_wdata", b_bus_wdata, ewd);
        cyc = 1;
        while (b_resp_valid !== 1'b1 && cyc < 20) begin
            if (cyc == 1) b_bus_gnt = 1;
            if (cyc == 2 + rvd) begin b_bus_rvalid = 1; b_bus_rdata = rd; end
            @(negedge clk);
            b_bus_gnt = 0; b_bus_rvalid = 0;
            cyc++;
        end
        chk("b_resp_cycle", 64'(cyc), 64'(exp_cyc));
        chk("b_resp_err", b_resp_err, tmo);
        chk("b_resp_cause", b_resp_cause, tmo ? (we ? 4'd7 : 4'd5) : 4'd0);
        chk("b_resp_rdata", b_resp_rdata, erd);
        b_resp_ready = 1;
        @(negedge clk);
        b_resp_ready = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before end of test");
        $fatal(1, "watchdog");
    end

    initial begin
        logic we, un, be;
        logic [1:0] sz;
        logic [31:0] ad;

        #1;
        chk_rst_a();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;

        acc_a(1, 2'd0, 0, 32'h8000_0003, 32'h0000_00AB, 32'h0, 0, 0, 0, 0);
        acc_a(0, 2'd1, 0, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0, 0, 0);
        chk("a_lh_signed_const", a_resp_rdata, 32'hFFFF_8001);
        acc_a(0, 2'd1, 1, 32'h8000_0002, 32'h0, 32'h8001_1234, 0, 0, 0, 0);
        chk("a_lhu_const", a_resp_rdata, 32'h0000_8001);
        acc_a(0, 2'd2, 0, 32'h8000_0006, 32'h0, 32'h0, 0, 0, 0, 0);
        acc_a(1, 2'd1, 0, 32'h0000_0001, 32'h1234, 32'h0, 0, 0, 0, 0);
        acc_a(0, 2'd3, 0, 32'h0000_0010, 32'h0, 32'h0, 0, 0, 0, 0);
        acc_a(1, 2'd1, 0, 32'h1000_0002, 32'hBEEF, 32'h0, 0, 3, 1, 5);
        acc_a(0, 2'd0, 0, 32'h1000_0001, 32'h0, 32'h1234_8056, 0, 2, 2, 1);
        acc_a(0, 2'd2, 0, 32'h2000_0000, 32'h0, 32'hDEAD_BEEF, 1, 0, 0, 0);
        acc_a(1, 2'd2, 0, 32'h2000_0004, 32'hCAFE_F00D, 32'h0, 1, 1, 0, 0);

        // Reset pulsed while an access waits for its completion.
        a_req_valid = 1; a_req_we = 0; a_req_size = 2'd2; a_req_addr = 32'h0000_0104;
        @(negedge clk);
        a_req_valid = 0; a_bus_gnt = 1;
        @(negedge clk);
        a_bus_gnt = 0;
        chk("a_in_wait", a_bus_req, 0);
        #2 rst_n = 0;
        #1 chk_rst_a();
        @(negedge clk);
        rst_n = 1;
        a_bus_rvalid = 1; a_bus_rdata = 32'h5555_5555;
        @(negedge clk);
        a_bus_rvalid = 0;
        @(negedge clk);
        chk("a_no_resp_after_rst", a_resp_valid, 0);
        acc_a(0, 2'd2, 0, 32'h0000_0104, 32'h0, 32'h7654_3210, 0, 0, 0, 0);

        for (int i = 0; i < 40; i++) begin
            we = 1'($urandom); un = 1'($urandom); sz = 2'($urandom);
            ad = $urandom;
            if ($urandom_range(0, 2) != 0) ad = ad & ~((32'd1 << sz) - 32'd1);
            be = ($urandom_range(0, 7) == 0);
            acc_a(we, sz, un, ad, $urandom, $urandom, be,
                  $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 2));
        end

        acc_b(1, 2'd3, 0, 32'h0000_0008, 64'h0123_4567_89AB_CDEF, 64'h0, 0);
        acc_b(0, 2'd3, 0, 32'h0000_0010, 64'h0, 64'hFEDC_BA98_7654_3210, 0);
        acc_b(0, 2'd2, 0, 32'h0000_0014, 64'h0, 64'h8765_4321_0000_0000, 1);
        acc_b(0, 2'd2, 1, 32'h0000_0014, 64'h0, 64'h8765_4321_0000_0000, 2);
        acc_b(0, 2'd1, 0, 32'h0000_0020, 64'h0, 64'h0, -1);
        b_bus_rvalid = 1; b_bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
        @(negedge clk);
        b_bus_rvalid = 0;
        @(negedge clk);
        chk("b_late_rvalid_ignored", b_resp_valid, 0);
        acc_b(0, 2'd0, 0, 32'h0000_0023, 64'h0, 64'h0000_0000_9900_0000, 0);
        acc_b(1, 2'd2, 0, 32'h0000_0024, 64'h1111_2222, 64'h0, 3);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
`default_nettype wire
